decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have InstrD  input  32  instruction from IF/ID register; 0 means bubble.
REQ-004 SHALL have PCPlus4D  input  32  word address of next sequential instruction (PC+1, word-indexed).
REQ-005 SHALL have RegWriteW  input  1  writeback enable.
REQ-006 SHALL have WriteRegW  input  5  writeback destination register.
REQ-007 SHALL have ResultW  input  32  writeback data.
REQ-008 SHALL have FlushE  input  1  load a bubble into ID/EX on this edge.
REQ-009 SHALL have PCSrcD  output  1  redirect fetch (taken branch or jump), combinational.
REQ-010 SHALL have PCBranchD  output  32  redirect target word address, combinational.
REQ-011 SHALL have BranchD  output  1  decoded beq/bne, for the hazard unit.
REQ-012 SHALL have RsD  output  5  InstrD[25:21], for the hazard unit.
REQ-013 SHALL have RtD  output  5  InstrD[20:16], for the hazard unit.
REQ-014 SHALL have CtrlE  output  8  registered {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}.
REQ-015 SHALL have RD1E  output  32  registered rs operand.
REQ-016 SHALL have RD2E  output  32  registered rt operand.
REQ-017 SHALL have RsE  output  5  registered rs index.
REQ-018 SHALL have RtE  output  5  registered rt index.
REQ-019 SHALL have RdE  output  5  registered rd index.
REQ-020 SHALL have SignImmE  output  32  registered sign-extended InstrD[15:0].

Function
REQ-021 SHALL decode: R-type (op 000000) funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; beq 000100; bne 000101; addi 001000; j 000010.
REQ-022 SHALL encode ALUControl: and 000, or 001, add 010, sub 110, slt 111; lw/sw/addi use add.
REQ-023 SHALL treat any unsupported opcode/funct, including InstrD=0, as a bubble: all control bits 0, PCSrcD=0.
REQ-024 SHALL hold a 32x32 register file with 2 combinational read ports and 1 synchronous write port; register 0 reads 0 and ignores writes.
REQ-025 SHALL bypass write to read: RegWriteW=1 with WriteRegW equal to a read index (non-zero) returns ResultW in that same cycle.
REQ-026 SHALL compare bypassed RD1/RD2 for beq (equal) and bne (not equal); PCSrcD = taken branch OR j.
REQ-027 SHALL compute branch PCBranchD = PCPlus4D + SignImm (32-bit, wraps mod 2^32, no shift); for j, PCBranchD = {PCPlus4D[31:26], InstrD[25:0]}.
REQ-028 SHALL register all E outputs each rising edge with latency 1; beq/bne/j/sw write no register (RegWrite=0).
REQ-029 SHALL on FlushE=1 clear CtrlE to 0 and all other E outputs to 0; FlushE overrides decode.
REQ-030 SHALL not forward from E/M; the hazard unit stalls D when branch sources are pending.

Reset
REQ-031 SHALL, while rst=1, asynchronously clear all ID/EX outputs and all 32 registers to 0; PCSrcD=0 whenever InstrD=0.
REQ-032 SHALL, on reset mid-operation, discard any same-edge writeback.

Structure
REQ-033 SHALL place opcode/funct constants, ALUControl encodings and CtrlE bit positions in the shared package pipeline_pkg.
REQ-034 SHALL instantiate one sub-module reg_file (2R1W, bypass, r0 hardwired).

Verification
REQ-035 SHALL cover: write ResultW=0x12 to r5, then addi r6,r5,3 (0x20A60003) -> next edge RD1E=0x12, SignImmE=3, ALUControl=010, ALUSrc=1, RegWrite=1.
REQ-036 SHALL cover: r1=r2=7, beq r1,r2,-2 with PCPlus4D=0x10 -> PCSrcD=1, PCBranchD=0x0E; bne same -> PCSrcD=0.
REQ-037 SHALL cover: j 0x40 with PCPlus4D=0x0400_0005 -> PCSrcD=1, PCBranchD=0x0400_0040.
REQ-038 SHALL cover: same-cycle writeback of 0xAA to r3 while decoding sub r4,r3,r3 -> RD1E=RD2E=0xAA; write to r0 -> r0 stays 0.
REQ-039 SHALL cover: FlushE=1 during lw -> CtrlE=0; InstrD=0 or opcode 111111 -> CtrlE=0, PCSrcD=0.
REQ-040 SHALL cover: rst asserted mid-stream -> all E outputs 0 immediately, all registers read 0 afterwards.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared decode constants for the pipeline: opcodes, R-type functs,
// ALUControl encodings, CtrlE bit positions and a sign-extension helper.
package pipeline_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // CtrlE layout: {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
    localparam int unsigned CTRL_W        = 8;
    localparam int unsigned CTRL_REGWRITE = 7;
    localparam int unsigned CTRL_MEMTOREG = 6;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_ALU_MSB  = 4;
    localparam int unsigned CTRL_ALU_LSB  = 2;
    localparam int unsigned CTRL_ALUSRC   = 1;
    localparam int unsigned CTRL_REGDST   = 0;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-to-read
// bypass, one synchronous write port, r0 hardwired to zero.
module reg_file
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // Synchronous write; reset clears every register and discards a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // Combinational reads: r0 is zero, a matching writeback is returned the same cycle.
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (we && (wa == ra1)) rd1 = wd;
        if (we && (wa == ra2)) rd2 = wd;
        if (ra1 == 5'd0) rd1 = '0;
        if (ra2 == 5'd0) rd2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: main decoder, register file read, early branch/jump
// resolution in D, and the ID/EX pipeline register.
module decode_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        PCSrcD,
    output logic [31:0] PCBranchD,
    output logic        BranchD,
    output logic [4:0]  RsD,
    output logic [4:0]  RtD,
    output logic [7:0]  CtrlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [31:0] SignImmE
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] ctrl_d;
    alu_ctrl_e         r_alu;
    logic              r_ok;
    logic              is_beq;
    logic              is_bne;
    logic              is_j;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       sign_imm;
    logic              regs_equal;

    assign op       = InstrD[31:26];
    assign funct    = InstrD[5:0];
    assign RsD      = InstrD[25:21];
    assign RtD      = InstrD[20:16];
    assign sign_imm = sign_ext(InstrD[15:0]);

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (InstrD[25:21]),
        .ra2 (InstrD[20:16]),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (RegWriteW),
        .wa  (WriteRegW),
        .wd  (ResultW)
    );

    // Main decoder; branches and jumps resolve here, so their E-stage controls stay zero.
    always_comb begin
        ctrl_d = '0;
        r_alu  = ALU_ADD;
        r_ok   = 1'b1;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  r_alu = ALU_ADD;
                    FN_SUB:  r_alu = ALU_SUB;
                    FN_AND:  r_alu = ALU_AND;
                    FN_OR:   r_alu = ALU_OR;
                    FN_SLT:  r_alu = ALU_SLT;
                    default: r_ok  = 1'b0;
                endcase
                if (r_ok) begin
                    ctrl_d[CTRL_REGWRITE]             = 1'b1;
                    ctrl_d[CTRL_ALU_MSB:CTRL_ALU_LSB] = r_alu;
                    ctrl_d[CTRL_REGDST]               = 1'b1;
                end
            end
            OP_LW: begin
                ctrl_d[CTRL_REGWRITE]             = 1'b1;
                ctrl_d[CTRL_MEMTOREG]             = 1'b1;
                ctrl_d[CTRL_ALU_MSB:CTRL_ALU_LSB] = ALU_ADD;
                ctrl_d[CTRL_ALUSRC]               = 1'b1;
            end
            OP_SW: begin
                ctrl_d[CTRL_MEMWRITE]             = 1'b1;
                ctrl_d[CTRL_ALU_MSB:CTRL_ALU_LSB] = ALU_ADD;
                ctrl_d[CTRL_ALUSRC]               = 1'b1;
            end
            OP_ADDI: begin
                ctrl_d[CTRL_REGWRITE]             = 1'b1;
                ctrl_d[CTRL_ALU_MSB:CTRL_ALU_LSB] = ALU_ADD;
                ctrl_d[CTRL_ALUSRC]               = 1'b1;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    assign regs_equal = (rd1 == rd2);
    assign BranchD    = is_beq | is_bne;
    assign PCSrcD     = (is_beq & regs_equal) | (is_bne & ~regs_equal) | is_j;
    assign PCBranchD  = is_j ? {PCPlus4D[31:26], InstrD[25:0]} : (PCPlus4D + sign_imm);

    // ID/EX register: reset and flush both load an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            RsE      <= '0;
            RtE      <= '0;
            RdE      <= '0;
            SignImmE <= '0;
        end else if (FlushE) begin
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            RsE      <= '0;
            RtE      <= '0;
            RdE      <= '0;
            SignImmE <= '0;
        end else begin
            CtrlE    <= ctrl_d;
            RD1E     <= rd1;
            RD2E     <= rd2;
            RsE      <= InstrD[25:21];
            RtE      <= InstrD[20:16];
            RdE      <= InstrD[15:11];
            SignImmE <= sign_imm;
        end
    end

endmodule
